// File: rtl/conv_accumulator.sv
// -----------------------------------------------------------------------------
// conv_accumulator
//
// Streaming frame accumulator that sits directly after the real subtractor in
// the temporal convolution core. Each frame is exactly TAPS signed difference
// samples. They are summed in a wide accumulator. The frame result is then
// saturated back to DATA_WIDTH and offered once over a valid/ready interface.
// While a result is waiting to be taken, no new samples are accepted.
//
// Parameters
//   DATA_WIDTH  width of in_data / out_data (two's complement)
//   ACC_WIDTH   accumulator width, >= DATA_WIDTH + clog2(TAPS)
//   TAPS        samples per frame, >= 2
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous frame abort; overrides both handshakes
//   in_data    signed sample from the subtractor
//   in_valid   in_data is valid
//   in_ready   block can take a sample (depends on state only)
//   out_data   saturated frame sum
//   out_valid  out_data is valid
//   out_ready  downstream takes out_data
//   out_sat    saturation was applied to out_data (qualified by out_valid)
// -----------------------------------------------------------------------------
module conv_accumulator #(
    parameter int DATA_WIDTH = 22,
    parameter int ACC_WIDTH  = 32,
    parameter int TAPS       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sat
);

    localparam int CNT_WIDTH = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_TAP = CNT_WIDTH'(TAPS - 1);

    // Parameter sanity: a too-narrow accumulator could wrap silently and the
    // saturation stage would then report a wrong result.
    if (TAPS < 2) begin : g_bad_taps
        $error("conv_accumulator: TAPS must be >= 2");
    end
    if (ACC_WIDTH < DATA_WIDTH + $clog2(TAPS)) begin : g_bad_acc
        $error("conv_accumulator: ACC_WIDTH must be >= DATA_WIDTH + clog2(TAPS)");
    end

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0]   count;

    logic [ACC_WIDTH-1:0]   in_ext;
    logic [ACC_WIDTH-1:0]   total;
    logic                   fits;
    logic [DATA_WIDTH-1:0]  sat_data;
    logic                   sat_flag;
    logic                   accept;

    // in_ready is decoded from state alone. It must not look at in_valid, or
    // the upstream could form a combinational loop through its own valid.
    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;

    // Sign-extend the sample. Then saturate the running total, including
    // this sample, to DATA_WIDTH.
    // The total fits in DATA_WIDTH when every bit from the MSB down to the
    // DATA_WIDTH sign position agrees. If they disagree, the true sign
    // (the MSB) selects the rail.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sat_data = '0;
        sat_flag = 1'b0;

        in_ext = {{(ACC_WIDTH - DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
        total  = acc + in_ext;
        fits   = (&total[ACC_WIDTH-1:DATA_WIDTH-1]) ||
                 (~|total[ACC_WIDTH-1:DATA_WIDTH-1]);

        if (fits) begin
            sat_data = total[DATA_WIDTH-1:0];
        end else if (total[ACC_WIDTH-1]) begin
            sat_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            sat_flag = 1'b1;
        end else begin
            sat_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            sat_flag = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else if (clear) begin
            // Abort the frame. A pending result is discarded. out_data is
            // left alone because it is meaningless without out_valid.
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (count == LAST_TAP) begin
                            out_data  <= sat_data;
                            out_sat   <= sat_flag;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            count     <= '0;
                            state     <= OUTPUT;
                        end else begin
                            acc   <= total;
                            count <= count + 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    // out_data/out_sat hold until the downstream takes them.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_accumulator.sv
// -----------------------------------------------------------------------------
// tb_conv_accumulator
//
// Self-checking bench for conv_accumulator with DATA_WIDTH=8, ACC_WIDTH=12 and
// TAPS=4. A frame-level reference model keeps the accepted samples of the
// current frame in a queue. When TAPS samples have been collected, it sums
// them with plain integer arithmetic and clamps the sum to the 8-bit range.
// Every cycle, all DUT outputs are compared with the model. Directed steps
// also check specific frame results. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_conv_accumulator;

    localparam int DW   = 8;
    localparam int AW   = 12;
    localparam int TAPS = 4;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sat;

    conv_accumulator #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .TAPS       (TAPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int            frame_q[$];
    bit            m_pend;
    logic [DW-1:0] m_data;
    bit            m_sat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp8(input int s);
        if (s > 127)       return 127;
        else if (s < -128) return -128;
        else               return s;
    endfunction

    task automatic model_reset();
        frame_q.delete();
        m_pend = 1'b0;
        m_data = '0;
        m_sat  = 1'b0;
    endtask

    // Apply one cycle of stimulus, advance the model, clock the DUT and check
    // every output 1 time unit after the edge.
    task automatic cycle(input bit v, input int d, input bit ordy, input bit clr);
        int s;
        in_valid  = v;
        in_data   = DW'(d);
        out_ready = ordy;
        clear     = clr;

        if (clr) begin
            frame_q.delete();
            m_pend = 1'b0;
            m_sat  = 1'b0;
        end else if (!m_pend) begin
            if (v) begin
                frame_q.push_back(d);
                if (frame_q.size() == TAPS) begin
                    s = 0;
                    foreach (frame_q[i]) s += frame_q[i];
                    m_data = DW'(clamp8(s));
                    m_sat  = (clamp8(s) != s);
                    m_pend = 1'b1;
                    frame_q.delete();
                end
            end
        end else if (ordy) begin
            m_pend = 1'b0;
        end

        @(posedge clk);
        #1;
        chk("in_ready",  32'(in_ready),  32'(!m_pend));
        chk("out_valid", 32'(out_valid), 32'(m_pend));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_sat",   32'(out_sat),   32'(m_sat));
    endtask

    // Four back-to-back samples. The last step is the accepting edge.
    task automatic frame4(input int a, input int b, input int c, input int d, input bit ordy);
        cycle(1'b1, a, ordy, 1'b0);
        cycle(1'b1, b, ordy, 1'b0);
        cycle(1'b1, c, ordy, 1'b0);
        cycle(1'b1, d, ordy, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sat",   32'(out_sat),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // Basic frame: 1+2+3+4 = 10, valid for one cycle only.
        frame4(1, 2, 3, 4, 1'b1);
        chk("sum_10", 32'(out_data), 32'd10);
        chk("sum_10_valid", 32'(out_valid), 32'd1);
        cycle(1'b0, 0, 1'b1, 1'b0);
        chk("sum_10_valid_drop", 32'(out_valid), 32'd0);
        chk("sum_10_ready_back", 32'(in_ready), 32'd1);

        // Saturation at both rails, plus a non-saturating mixed frame.
        frame4(100, 100, 100, 100, 1'b1);
        chk("sat_pos", 32'(out_data), 32'h7f);
        chk("sat_pos_flag", 32'(out_sat), 32'd1);
        cycle(1'b0, 0, 1'b1, 1'b0);
        frame4(-100, -100, -100, -100, 1'b1);
        chk("sat_neg", 32'(out_data), 32'h80);
        chk("sat_neg_flag", 32'(out_sat), 32'd1);
        cycle(1'b0, 0, 1'b1, 1'b0);
        frame4(-128, 127, -1, 0, 1'b1);
        chk("sum_m2", 32'(out_data), 32'hfe);
        chk("sum_m2_flag", 32'(out_sat), 32'd0);
        cycle(1'b0, 0, 1'b1, 1'b0);

        // in_valid gaps: ignored values presented with in_valid=0.
        cycle(1'b1, 5, 1'b1, 1'b0);
        cycle(1'b0, 99, 1'b1, 1'b0);
        cycle(1'b1, -3, 1'b1, 1'b0);
        cycle(1'b0, -77, 1'b1, 1'b0);
        cycle(1'b1, 7, 1'b1, 1'b0);
        cycle(1'b0, 55, 1'b1, 1'b0);
        cycle(1'b1, -9, 1'b1, 1'b0);
        chk("gap_sum_0", 32'(out_data), 32'd0);
        chk("gap_valid", 32'(out_valid), 32'd1);
        cycle(1'b0, 0, 1'b1, 1'b0);

        // Backpressure: the result is held while out_ready is low, and
        // inputs are refused.
        frame4(20, 20, 20, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 50, 1'b0, 1'b0);
            chk("bp_hold_data", 32'(out_data), 32'd61);
        end
        cycle(1'b1, 50, 1'b1, 1'b0);   // handshake; this input is not taken
        chk("bp_released", 32'(out_valid), 32'd0);
        frame4(1, 1, 1, 1, 1'b1);
        chk("after_bp_sum_4", 32'(out_data), 32'd4);
        cycle(1'b0, 0, 1'b1, 1'b0);

        // clear mid-frame drops the sample presented in the same cycle.
        cycle(1'b1, 10, 1'b1, 1'b0);
        cycle(1'b1, 20, 1'b1, 1'b0);
        cycle(1'b1, 30, 1'b1, 1'b1);
        frame4(4, 4, 4, 4, 1'b1);
        chk("clear_sum_16", 32'(out_data), 32'd16);
        cycle(1'b0, 0, 1'b1, 1'b0);

        // clear while a result is pending discards it.
        frame4(9, 9, 9, 9, 1'b0);
        chk("pend_valid", 32'(out_valid), 32'd1);
        cycle(1'b0, 0, 1'b0, 1'b1);
        chk("clear_pend_valid", 32'(out_valid), 32'd0);
        chk("clear_pend_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset between clock edges, mid-frame.
        cycle(1'b1, 3, 1'b1, 1'b0);
        cycle(1'b1, 3, 1'b1, 1'b0);
        cycle(1'b1, 3, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_out_data",  32'(out_data),  32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_sat",   32'(out_sat),   32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        frame4(2, 2, 2, 2, 1'b1);
        chk("post_rst_sum_8", 32'(out_data), 32'd8);
        cycle(1'b0, 0, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 255)) - 128,
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_accumulator.md
Name: conv_accumulator

Overview:
- Streaming accumulator directly downstream of the real subtractor in the temporal convolution core.
- Consumes one signed DATA_WIDTH difference sample per handshake and sums exactly TAPS samples per frame in a wide accumulator.
- Emits one saturated DATA_WIDTH result per frame over a valid/ready output interface to the next core stage.

Parameters:
- DATA_WIDTH, 22, width of input samples and output result (2's complement).
- ACC_WIDTH, 32, internal accumulator width. Must be >= DATA_WIDTH + clog2(TAPS); checked by elaboration assertion.
- TAPS, 16, samples per frame. Must be >= 2.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous frame abort, active-high.
- in_data  input  DATA_WIDTH  signed sample (subtractor output).
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts a sample this cycle.
- out_data  output  DATA_WIDTH  saturated frame sum.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_sat  output  1  saturation occurred on out_data; qualified by out_valid.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - acc=0, count=0, state=ACCUM.
  - out_data=0, out_valid=0, out_sat=0.
  - in_ready=1 once released.
- Input handshake: sample accepted on a rising edge with in_valid && in_ready. in_ready is a pure function of state (1 in ACCUM, 0 in OUTPUT). It never depends on in_valid.
- State ACCUM:
  - On accept, count < TAPS-1: acc <= acc + sext(in_data); count++.
  - On accept, count == TAPS-1: total = acc + sext(in_data); out_data <= sat(total); out_sat <= (saturation applied); out_valid <= 1; acc <= 0; count <= 0; state <= OUTPUT.
  - in_valid gaps are allowed; acc and count hold while no accept.
- State OUTPUT:
  - in_ready=0.
  - out_data and out_sat are stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid <= 0; state <= ACCUM. in_ready goes high the next cycle.
- Latency: out_valid rises on the edge that accepts the TAPS-th sample, i.e. the first cycle after that handshake. Minimum frame period is TAPS+1 cycles.
- Arithmetic:
  - in_data is sign-extended to ACC_WIDTH. acc wraps modulo 2^ACC_WIDTH, which cannot occur with legal parameters.
  - sat(): if total > 2^(DATA_WIDTH-1)-1, output max positive; if total < -2^(DATA_WIDTH-1), output min negative; otherwise output the low DATA_WIDTH bits.
- clear (synchronous, priority over all handshakes in the same cycle):
  - acc=0, count=0, out_valid=0, out_sat=0, state=ACCUM.
  - Sample presented that cycle is dropped. A pending output is discarded. out_data keeps its last value.
- Simultaneous out_ready handshake and a new in_valid in OUTPUT: the input is not accepted (in_ready=0).
- out_valid never deasserts without out_ready or clear/reset.

Test Plan (bench params DATA_WIDTH=8, ACC_WIDTH=12, TAPS=4):
- Inputs 1,2,3,4 back-to-back, out_ready=1 -> out_data=10, out_sat=0, out_valid high exactly 1 cycle, one cycle after the 4th accept; in_ready high again the following cycle.
- Inputs 100,100,100,100 -> out_data=127, out_sat=1. Inputs -100 x4 -> out_data=-128 (0x80), out_sat=1. Inputs -128,127,-1,0 -> out_data=-2, out_sat=0.
- Inputs 5,-3,7,-9 with in_valid toggling every other cycle -> out_data=0. Ignored samples presented while in_valid=0 do not change the sum.
- Frame completes with out_ready held low 5 cycles -> out_valid=1 and out_data stable for 5 cycles, in_ready=0 throughout. After out_ready=1: a handshake, then next frame 1,1,1,1 -> 4.
- After 2 accepted samples (10,20), pulse clear concurrently with in_valid=1 on sample 30 -> 30 dropped. Next 4,4,4,4 -> out_data=16. clear during a pending output -> out_valid=0 next cycle, no handshake observed.
- Assert rst_n low asynchronously mid-frame (between clock edges, after 3 samples) -> all outputs 0 immediately. After release, frame 2,2,2,2 -> out_data=8.
